machine_timer: RTL and testbench

- Memory-mapped machine timer peripheral that sources the timer interrupt consumed by the core-local interrupt controller.
- Counts prescaled clock ticks and compares the count against a programmable compare value.
- On a match, latches a pending flag and drives a level interrupt onto the core interrupt bus (bit 0 = timer).
- Sits on the peripheral bus; software clears the pending flag from the trap handler before `mret`.

---
 rtl/machine_timer.sv | 57 +++++
 tb/tb_machine_timer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// machine_timer: bus-mapped prescaled counter with compare match, pending flag and level timer interrupt
module machine_timer #(
  parameter int ADDR_W  = 4,
  parameter int PRESC_W = 16,
  parameter int INT_W   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic [INT_W-1:0]  int_o
);
  logic en, ie, pend, ar;
  logic [PRESC_W-1:0] presc, psc;
  logic [31:0] count, cmp, rd_val;
  logic [1:0] off;
  logic wr_ctrl, wr_presc, wr_count, wr_cmp, tick, match, set_pend, clr_pend, unused;
  assign off      = addr_i[3:2];
  assign unused   = ^addr_i;
  assign wr_ctrl  = req_i && we_i && off == 2'd0;
  assign wr_presc = req_i && we_i && off == 2'd1;
  assign wr_count = req_i && we_i && off == 2'd2;
  assign wr_cmp   = req_i && we_i && off == 2'd3;
  assign tick     = en && psc == presc;
  assign match    = count == cmp;
  // a COUNT write on a tick edge suppresses that edge's match
  assign set_pend = tick && match && !wr_count;
  assign clr_pend = wr_ctrl && wdata_i[2];
  assign int_o    = {{(INT_W-1){1'b0}}, pend & ie};
  always_comb
    rd_val = off == 2'd0 ? {28'd0, ar, pend, ie, en} :
             off == 2'd1 ? 32'(presc) :
             off == 2'd2 ? count : cmp;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      {en, ie, pend, ar} <= '0;
      presc   <= '0;
      psc     <= '0;
      count   <= '0;
      cmp     <= '0;
      rdata_o <= '0;
      ack_o   <= 1'b0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= (req_i && !we_i) ? rd_val : '0;
      if (wr_ctrl) {ar, ie, en} <= {wdata_i[3], wdata_i[1:0]};
      pend <= set_pend | (pend & ~clr_pend);
      if (wr_presc) presc <= wdata_i[PRESC_W-1:0];
      if (wr_cmp) cmp <= wdata_i;
      count <= wr_count ? wdata_i : tick ? ((match && ar) ? '0 : count + 32'd1) : count;
      psc <= (!en || tick || wr_presc || wr_count || (wr_ctrl && !wdata_i[0])) ? '0 : psc + PRESC_W'(1);
    end
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: vector table plus timed sequences; bus read data checked through a scoreboard queue
module tb_machine_timer;
  logic clk = 1'b0, rstn = 1'b0, req = 1'b0, we = 1'b0;
  logic [3:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic ack, req_q;
  logic [7:0] irq;
  int checks = 0, errors = 0;
  logic [31:0] sb[$];

  typedef struct {logic we; logic [3:0] addr; logic [31:0] data; logic [31:0] exp;} vec_t;
  vec_t tbl[16];

  machine_timer dut (
    .clk(clk), .rstn(rstn), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .int_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // every accepted request must ack next cycle with the queued read data
  always @(posedge clk) begin
    req_q = req;
    #1;
    if (rstn) begin
      chk("ack", 32'(ack), 32'(req_q));
      if (ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got ack with empty queue, expected queued item");
        end else chk("rdata", rdata, sb.pop_front());
      end
    end
  end

  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
    req = 1'b1; we = w; addr = a; wdata = d;
    sb.push_back(w ? 32'd0 : e);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'd0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    bus(1'b0, a, 32'd0, e);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 4'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 4'h4, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 4'h8, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 4'hC, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 32'h0};
    tbl[5]  = '{1'b0, 4'h4, 32'h0, 32'h0000FFFF};
    tbl[6]  = '{1'b1, 4'hC, 32'hDEADBEEF, 32'h0};
    tbl[7]  = '{1'b0, 4'hC, 32'h0, 32'hDEADBEEF};
    tbl[8]  = '{1'b1, 4'h8, 32'h12345678, 32'h0};
    tbl[9]  = '{1'b0, 4'h8, 32'h0, 32'h12345678};
    tbl[10] = '{1'b1, 4'h0, 32'hFFFFFFFA, 32'h0};
    tbl[11] = '{1'b0, 4'h0, 32'h0, 32'h0000000A};
    tbl[12] = '{1'b1, 4'h0, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 4'h4, 32'h0, 32'h0};
    tbl[14] = '{1'b1, 4'h8, 32'h0, 32'h0};
    tbl[15] = '{1'b1, 4'hC, 32'h0, 32'h0};
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_int", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    // back-to-back register accesses
    for (int i = 0; i < 16; i++) begin
      req = 1'b1; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].data;
      sb.push_back(tbl[i].we ? 32'd0 : tbl[i].exp);
      @(negedge clk);
    end
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    // auto-reload match at CMP=5, prescale 0
    wr(4'hC, 32'd5);
    wr(4'h0, 32'hB);
    repeat (5) @(negedge clk);
    chk("int_before_match", 32'(irq), 32'd0);
    @(negedge clk);
    chk("int_at_match", 32'(irq), 32'd1);
    rd(4'h8, 32'd0);
    chk("int_level_held", 32'(irq), 32'd1);
    wr(4'h0, 32'hF);
    chk("int_cleared", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    wr(4'h0, 32'hF);
    chk("set_beats_clear", 32'(irq), 32'd1);
    rd(4'h8, 32'd0);
    wr(4'h0, 32'h4);
    chk("int_disabled", 32'(irq), 32'd0);
    // prescale 3, CMP=2, no auto-reload
    wr(4'h8, 32'd0);
    wr(4'h4, 32'd3);
    wr(4'hC, 32'd2);
    wr(4'h0, 32'h1);
    repeat (7) @(negedge clk);
    rd(4'h8, 32'd1);
    repeat (3) @(negedge clk);
    rd(4'h0, 32'h1);
    rd(4'h0, 32'h5);
    rd(4'h8, 32'd3);
    repeat (2) @(negedge clk);
    rd(4'h8, 32'd4);
    chk("pend_ie_off", 32'(irq), 32'd0);
    wr(4'h0, 32'h3);
    chk("ie_on", 32'(irq), 32'd1);
    // wrap-around from all ones, match on the tick after wrap
    wr(4'h0, 32'h4);
    wr(4'h4, 32'd0);
    wr(4'hC, 32'd0);
    wr(4'h8, 32'hFFFFFFFF);
    rd(4'h8, 32'hFFFFFFFF);
    wr(4'h0, 32'h1);
    @(negedge clk);
    rd(4'h0, 32'h1);
    rd(4'h0, 32'h5);
    rd(4'h8, 32'd2);
    wr(4'h0, 32'h3);
    chk("int_before_reset", 32'(irq), 32'd1);
    // asynchronous reset while an ack is in flight
    req = 1'b1; we = 1'b0; addr = 4'h0;
    sb.push_back(32'h7);
    @(posedge clk);
    #3;
    req = 1'b0;
    rstn = 1'b0;
    #1;
    chk("async_ack", 32'(ack), 32'd0);
    chk("async_rdata", rdata, 32'd0);
    chk("async_int", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rd(4'h0, 32'd0);
    rd(4'h4, 32'd0);
    rd(4'h8, 32'd0);
    rd(4'hC, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
